// File: rtl/plca_txop_table_pkg.sv
// Shared constants and FSM encoding for the PLCA TXOP claim table.
package plca_txop_table_pkg;

    localparam int unsigned NUM_IDS      = 256;
    localparam int unsigned CLAIM_CYCLES = 3;
    localparam int unsigned CNT_W        = 2;
    localparam int unsigned ID_W         = 8;
    localparam int unsigned HARD_W       = 9;

    localparam logic [ID_W-1:0]  PICK_NONE = 8'hFF;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CLAIM_TH  = CNT_W'(CLAIM_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StPick,
        StDone
    } state_e;

endpackage

// File: rtl/plca_txop_scan.sv
// Circular index generator shared by the clear sweep and the free-ID search.
module plca_txop_scan
    import plca_txop_table_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            clear_mode_i,
    input  logic            step_i,
    input  logic [ID_W-1:0] seed_i,
    input  logic [ID_W-1:0] node_count_i,
    output logic [ID_W-1:0] idx_o,
    output logic            last_o
);

    logic [ID_W-1:0]   idx_q, idx_d;
    logic [HARD_W-1:0] n_q, n_d;
    logic              mode_q, mode_d;
    logic [ID_W-1:0]   seed_clamped;
    logic [HARD_W-1:0] idx_inc;
    logic [HARD_W-1:0] bound;

    always_comb begin
        seed_clamped = ((seed_i == '0) || (seed_i >= node_count_i)) ? 8'd1 : seed_i;
        idx_inc      = {1'b0, idx_q} + 9'd1;
        // Pick bound is re-read every cycle so a node_count change takes effect mid-sweep.
        bound        = mode_q ? HARD_W'(NUM_IDS) : ({1'b0, node_count_i} - 9'd1);
        last_o       = (n_q + 9'd1) >= bound;
        idx_o        = idx_q;

        idx_d  = idx_q;
        n_d    = n_q;
        mode_d = mode_q;
        if (start_i) begin
            idx_d  = clear_mode_i ? '0 : seed_clamped;
            n_d    = '0;
            mode_d = clear_mode_i;
        end else if (step_i) begin
            n_d = n_q + 9'd1;
            if (mode_q) begin
                idx_d = idx_inc[ID_W-1:0];
            end else if (idx_inc >= {1'b0, node_count_i}) begin
                idx_d = 8'd1;
            end else begin
                idx_d = idx_inc[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q  <= '0;
            n_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            n_q    <= n_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: rtl/plca_txop_table.sv
// Per-ID TXOP claim counters with hard-claim tracking, table clear and free-ID search.
module plca_txop_table
    import plca_txop_table_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [ID_W-1:0] plca_node_count_i,
    input  logic            txop_valid_i,
    input  logic [ID_W-1:0] txop_id_i,
    input  logic            txop_busy_i,
    input  logic            clear_req_i,
    output logic            clear_done_o,
    input  logic [ID_W-1:0] query_id_i,
    output logic            hard_claiming_o,
    output logic            max_hard_claim_o,
    input  logic            pick_req_i,
    input  logic [ID_W-1:0] pick_seed_i,
    output logic            pick_done_o,
    output logic            pick_found_o,
    output logic [ID_W-1:0] pick_id_o,
    output logic            busy_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NUM_IDS];
    logic [HARD_W-1:0] hard_cnt_q, hard_cnt_d;
    logic              hard_claiming_q, max_hard_claim_q;
    logic              clear_done_q, clear_done_d;
    logic              pick_found_q, pick_found_d;
    logic [ID_W-1:0]   pick_id_q, pick_id_d;

    logic              scan_start, scan_clear, scan_step, scan_last;
    logic [ID_W-1:0]   scan_idx;

    logic              upd_en;
    logic [CNT_W-1:0]  upd_old, upd_new, chk_val;
    logic              wr_en;
    logic [ID_W-1:0]   wr_idx;
    logic [CNT_W-1:0]  wr_val;

    plca_txop_scan u_scan (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (scan_start),
        .clear_mode_i (scan_clear),
        .step_i       (scan_step),
        .seed_i       (pick_seed_i),
        .node_count_i (plca_node_count_i),
        .idx_o        (scan_idx),
        .last_o       (scan_last)
    );

    always_comb begin
        upd_en  = txop_valid_i && (txop_id_i < plca_node_count_i) &&
                  ((state_q == StIdle) || (state_q == StPick));
        upd_old = cnt_q[txop_id_i];
        upd_new = txop_busy_i ? ((upd_old == CNT_MAX) ? upd_old : upd_old + 1'b1) : '0;
        // The pick sweep must see an update landing on the entry it is checking.
        chk_val = (upd_en && (txop_id_i == scan_idx)) ? upd_new : cnt_q[scan_idx];

        hard_cnt_d = hard_cnt_q;
        if (upd_en && (txop_id_i != '0)) begin
            if ((upd_new >= CLAIM_TH) && (upd_old < CLAIM_TH)) begin
                hard_cnt_d = hard_cnt_q + 9'd1;
            end else if ((upd_old >= CLAIM_TH) && (upd_new < CLAIM_TH)) begin
                hard_cnt_d = hard_cnt_q - 9'd1;
            end
        end

        state_d      = state_q;
        scan_start   = 1'b0;
        scan_clear   = 1'b0;
        scan_step    = 1'b0;
        clear_done_d = 1'b0;
        pick_found_d = pick_found_q;
        pick_id_d    = pick_id_q;

        unique case (state_q)
            StIdle: begin
                if (clear_req_i) begin
                    state_d    = StClear;
                    scan_start = 1'b1;
                    scan_clear = 1'b1;
                    hard_cnt_d = '0;
                end else if (pick_req_i) begin
                    state_d    = StPick;
                    scan_start = 1'b1;
                end
            end
            StClear: begin
                scan_step = 1'b1;
                if (scan_last) begin
                    state_d      = StIdle;
                    clear_done_d = 1'b1;
                end
            end
            StPick: begin
                scan_step = 1'b1;
                if (chk_val == '0) begin
                    state_d      = StDone;
                    pick_found_d = 1'b1;
                    pick_id_d    = scan_idx;
                end else if (scan_last) begin
                    state_d      = StDone;
                    pick_found_d = 1'b0;
                    pick_id_d    = PICK_NONE;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        wr_en  = upd_en;
        wr_idx = txop_id_i;
        wr_val = upd_new;
        if (state_q == StClear) begin
            wr_en  = 1'b1;
            wr_idx = scan_idx;
            wr_val = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (wr_en) begin
            cnt_q[wr_idx] <= wr_val;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= StIdle;
            hard_cnt_q       <= '0;
            hard_claiming_q  <= 1'b0;
            max_hard_claim_q <= 1'b0;
            clear_done_q     <= 1'b0;
            pick_found_q     <= 1'b0;
            pick_id_q        <= PICK_NONE;
        end else begin
            state_q          <= state_d;
            hard_cnt_q       <= hard_cnt_d;
            hard_claiming_q  <= cnt_q[query_id_i] >= CLAIM_TH;
            max_hard_claim_q <= hard_cnt_q >= ({1'b0, plca_node_count_i} - 9'd1);
            clear_done_q     <= clear_done_d;
            pick_found_q     <= pick_found_d;
            pick_id_q        <= pick_id_d;
        end
    end

    assign clear_done_o     = clear_done_q;
    assign hard_claiming_o  = hard_claiming_q;
    assign max_hard_claim_o = max_hard_claim_q;
    assign pick_done_o      = (state_q == StDone);
    assign pick_found_o     = pick_found_q;
    assign pick_id_o        = pick_id_q;
    assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_plca_txop_table.sv
// Scoreboard bench for plca_txop_table: done events queued at issue, checked by a monitor.
module tb_plca_txop_table;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] node_count;
    logic       txop_valid;
    logic [7:0] txop_id;
    logic       txop_busy;
    logic       clear_req;
    logic       clear_done;
    logic [7:0] query_id;
    logic       hard_claiming;
    logic       max_hard_claim;
    logic       pick_req;
    logic [7:0] pick_seed;
    logic       pick_done;
    logic       pick_found;
    logic [7:0] pick_id;
    logic       busy;

    always #5 clk = ~clk;

    plca_txop_table dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .plca_node_count_i(node_count),
        .txop_valid_i     (txop_valid),
        .txop_id_i        (txop_id),
        .txop_busy_i      (txop_busy),
        .clear_req_i      (clear_req),
        .clear_done_o     (clear_done),
        .query_id_i       (query_id),
        .hard_claiming_o  (hard_claiming),
        .max_hard_claim_o (max_hard_claim),
        .pick_req_i       (pick_req),
        .pick_seed_i      (pick_seed),
        .pick_done_o      (pick_done),
        .pick_found_o     (pick_found),
        .pick_id_o        (pick_id),
        .busy_o           (busy)
    );

    typedef struct {
        bit          is_pick;
        bit          found;
        logic [7:0]  id;
        int unsigned cyc;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected event, on the expected cycle.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en && (pick_done || clear_done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {30'd0, pick_done, clear_done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_kind", {30'd0, pick_done, clear_done}, e.is_pick ? 32'd2 : 32'd1);
                check("done_cycle", cyc, e.cyc);
                if (e.is_pick) begin
                    check("pick_found", {31'd0, pick_found}, {31'd0, e.found});
                    check("pick_id", {24'd0, pick_id}, {24'd0, e.id});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic txop(input logic [7:0] id, input logic b);
        txop_valid = 1'b1;
        txop_id    = id;
        txop_busy  = b;
        tick(1);
        txop_valid = 1'b0;
    endtask

    task automatic round(input logic [7:0] lo, input logic [7:0] hi, input logic b,
                         input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = int'(lo); i <= int'(hi); i++) txop(8'(i), b);
        end
    endtask

    task automatic push_ev(input bit is_pick, input bit found, input logic [7:0] id,
                           input int unsigned lat);
        ev_t e;
        e.is_pick = is_pick;
        e.found   = found;
        e.id      = id;
        e.cyc     = cyc + lat;
        exp_q.push_back(e);
    endtask

    task automatic pick(input logic [7:0] seed, input bit found, input logic [7:0] id,
                        input int unsigned lat);
        push_ev(1'b1, found, id, lat);
        pick_seed = seed;
        pick_req  = 1'b1;
        tick(1);
        pick_req  = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
        tick(1);
    endtask

    task automatic query(input logic [7:0] q, input logic exp_hc, input logic exp_max,
                         input string name);
        query_id = q;
        tick(2);
        @(negedge clk);
        check({name, "_hard_claiming"}, {31'd0, hard_claiming}, {31'd0, exp_hc});
        check({name, "_max_hard_claim"}, {31'd0, max_hard_claim}, {31'd0, exp_max});
        tick(1);
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_pick_id"}, {24'd0, pick_id}, 32'hFF);
        check({name, "_pick_found"}, {31'd0, pick_found}, 32'd0);
        check({name, "_pick_done"}, {31'd0, pick_done}, 32'd0);
        check({name, "_clear_done"}, {31'd0, clear_done}, 32'd0);
        check({name, "_hard_claiming"}, {31'd0, hard_claiming}, 32'd0);
        check({name, "_max_hard_claim"}, {31'd0, max_hard_claim}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        node_count = 8'd8;
        txop_valid = 1'b0;
        txop_id    = '0;
        txop_busy  = 1'b0;
        clear_req  = 1'b0;
        query_id   = 8'd5;
        pick_req   = 1'b0;
        pick_seed  = '0;
        tick(3);
        check_reset_outputs("reset");
        reset  = 1'b0;
        mon_en = 1'b1;
        tick(1);

        // IDs 1..7 busy three cycles in a row: all hard-claimed.
        round(8'd1, 8'd7, 1'b1, 3);
        query(8'd5, 1'b1, 1'b1, "claim_all");

        // One idle TXOP on ID 5 drops it; hard_cnt 6 still meets a 7-node bound.
        txop(8'd5, 1'b0);
        query(8'd5, 1'b0, 1'b0, "id5_idle");
        node_count = 8'd7;
        query(8'd1, 1'b1, 1'b1, "nc7");
        node_count = 8'd8;

        // Only ID 3 free; search from 6 wraps 7 -> 1.
        round(8'd5, 8'd5, 1'b1, 3);
        txop(8'd3, 1'b0);
        pick(8'd6, 1'b1, 8'd3, 6);
        drain(20);

        // Everything claimed: seed 0 clamps to 1, seven checks, nothing found.
        round(8'd3, 8'd3, 1'b1, 3);
        pick(8'd0, 1'b0, 8'hFF, 8);
        drain(20);

        // Out-of-range seed clamps to 1; ID 2 freed.
        txop(8'd2, 1'b0);
        pick(8'd200, 1'b1, 8'd2, 3);
        drain(20);

        // ID 0 counts but never contributes to max_hard_claim; IDs >= node_count ignored.
        round(8'd0, 8'd0, 1'b1, 3);
        query(8'd0, 1'b1, 1'b0, "id0");
        round(8'd10, 8'd10, 1'b1, 3);
        query(8'd10, 1'b0, 1'b0, "id_out_of_range");

        // Busy update to ID 2 on the cycle it is checked must make it look taken.
        push_ev(1'b1, 1'b0, 8'hFF, 8);
        pick_seed  = 8'd2;
        pick_req   = 1'b1;
        tick(1);
        pick_req   = 1'b0;
        txop(8'd2, 1'b1);
        drain(20);

        // Clear and pick together: clear wins; strobes and requests during the sweep ignored.
        push_ev(1'b0, 1'b0, 8'h00, 257);
        clear_req = 1'b1;
        pick_req  = 1'b1;
        pick_seed = 8'd1;
        tick(1);
        clear_req = 1'b0;
        pick_req  = 1'b0;
        tick(20);
        round(8'd4, 8'd4, 1'b1, 3);
        pick_req = 1'b1;
        tick(1);
        pick_req = 1'b0;
        @(negedge clk);
        check("sweep_busy", {31'd0, busy}, 32'd1);
        tick(1);
        drain(400);
        query(8'd4, 1'b0, 1'b0, "after_clear_id4");
        query(8'd1, 1'b0, 1'b0, "after_clear_id1");
        pick(8'd1, 1'b1, 8'd1, 2);
        drain(20);

        // Reset in the middle of a long search: no done pulse, reset outputs.
        round(8'd1, 8'd7, 1'b1, 3);
        pick_seed = 8'd1;
        pick_req  = 1'b1;
        tick(1);
        pick_req  = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_reset_outputs("mid_pick_reset");
        tick(12);
        pick(8'd3, 1'b1, 8'd3, 2);
        drain(20);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
